// File: rtl/pulse_gen.sv
// -----------------------------------------------------------------------------
// pulse_gen
//   Programmable tick generator. A divisor register (div_q) sets the pulse
//   period in clock cycles. Two run modes:
//     continuous - one-cycle pulse every div_q cycles while enabled
//     burst      - burst_len pulses, then a done strobe, then back to IDLE
//   The divisor may only be reloaded while idle; a load attempt while running
//   is dropped and flagged for one cycle on load_err.
//
// Ports
//   Clk        rising-edge clock
//   Reset_n    asynchronous active-low reset
//   enable     global run gate (dropping it aborts any run)
//   mode       0 = continuous, 1 = burst (only looked at in IDLE/CONT)
//   start      burst trigger, sampled in IDLE only
//   load       divisor-load strobe
//   div_in     new divisor (0 is stored as 1)
//   burst_len  pulses per burst (0 is treated as 1)
//   pulse      registered one-cycle tick
//   busy       high while in CONT or BURST
//   done       one-cycle strobe coincident with the last burst pulse
//   load_err   one-cycle strobe after a rejected load
// -----------------------------------------------------------------------------
module pulse_gen #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 5000,
  parameter int BW          = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [BW-1:0]    burst_len,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic             load_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONT  = 2'd1,
    S_BURST = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] cnt_q;
  logic [BW-1:0]    blen_q;
  logic [BW-1:0]    bcnt_q;
  logic             pulse_q;
  logic             done_q;
  logic             lerr_q;

  logic [WIDTH-1:0] div_ld;
  logic [BW-1:0]    blen_ld;
  logic             wrap;
  logic             last;

  // Zero divisor / zero burst length are clamped to 1.
  assign div_ld  = (div_in == '0)    ? WIDTH'(1) : div_in;
  assign blen_ld = (burst_len == '0) ? BW'(1)    : burst_len;

  // div_q >= 1 always, so div_q-1 never underflows and cnt_q stays below it.
  assign wrap = (cnt_q == div_q - WIDTH'(1));
  // blen_q >= 1 once latched at burst entry.
  assign last = (bcnt_q == blen_q - BW'(1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      div_q   <= WIDTH'(DEFAULT_DIV);
      cnt_q   <= '0;
      blen_q  <= '0;
      bcnt_q  <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      lerr_q  <= load && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          cnt_q  <= '0;
          bcnt_q <= '0;
          // A load on the entry edge is already visible to the new run,
          // since the wrap compare only starts on the following cycle.
          if (load) div_q <= div_ld;
          if (enable && !mode) begin
            state_q <= S_CONT;
          end else if (enable && mode && start) begin
            state_q <= S_BURST;
            blen_q  <= blen_ld;
          end
        end
        S_CONT: begin
          if (!enable || mode) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (wrap) begin
            cnt_q   <= '0;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + WIDTH'(1);
          end
        end
        S_BURST: begin
          // done_q high means the final pulse is on the outputs right now;
          // leave on this edge so busy drops the cycle after done.
          if (!enable || done_q) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bcnt_q  <= '0;
          end else if (wrap) begin
            cnt_q   <= '0;
            pulse_q <= 1'b1;
            if (last) begin
              done_q <= 1'b1;
              bcnt_q <= '0;
            end else begin
              bcnt_q <= bcnt_q + BW'(1);
            end
          end else begin
            cnt_q <= cnt_q + WIDTH'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pulse    = pulse_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign load_err = lerr_q;

endmodule

// File: tb/tb_pulse_gen.sv
module tb_pulse_gen;

  localparam int WIDTH = 16;
  localparam int DDIV  = 5000;
  localparam int BW    = 8;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             enable, mode, start, load;
  logic [WIDTH-1:0] div_in;
  logic [BW-1:0]    burst_len;
  logic             pulse, busy, done, load_err;

  int checks = 0;
  int errors = 0;

  // Scoreboard: edge indices (relative to the run-entry edge) at which a
  // pulse / done is expected to be visible.
  int exp_pulse[$];
  int exp_done[$];

  pulse_gen #(.WIDTH(WIDTH), .DEFAULT_DIV(DDIV), .BW(BW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .enable(enable), .mode(mode),
    .start(start), .load(load), .div_in(div_in), .burst_len(burst_len),
    .pulse(pulse), .busy(busy), .done(done), .load_err(load_err)
  );

  always #5 Clk = ~Clk;

  task automatic test_reset();
    Reset_n = 1'b1; enable = 0; mode = 0; start = 0; load = 0;
    div_in = '0; burst_len = '0;
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({pulse, busy, done, load_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 0000", {pulse, busy, done, load_err});
    end
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(posedge Clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %b, expected 0", busy);
    end
  endtask

  // REQ-021 style: default divisor, 5 pulses in continuous mode.
  task automatic test_continuous();
    for (int i = 1; i <= 5; i++) exp_pulse.push_back(i * DDIV);
    enable = 1; mode = 0;
    @(posedge Clk); #1;  // entry edge
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL cont_busy: got %b, expected 1", busy);
    end
    for (int k = 1; k <= 5 * DDIV + 3; k++) begin
      @(posedge Clk); #1;
      if (pulse === 1'b1) begin
        checks++;
        if (exp_pulse.size() == 0 || exp_pulse[0] != k) begin
          errors++;
          $display("FAIL cont_pulse: pulse at edge %0d, expected edge %0d", k,
                   (exp_pulse.size() != 0) ? exp_pulse[0] : -1);
        end else void'(exp_pulse.pop_front());
      end
    end
    checks++;
    if (exp_pulse.size() != 0) begin
      errors++; $display("FAIL cont_missing: %0d pulses missing, expected 0", exp_pulse.size());
      exp_pulse.delete();
    end
    enable = 0;
    @(posedge Clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL cont_exit_busy: got %b, expected 0", busy);
    end
  endtask

  // Load + burst entry on the same edge: div 4, 3 pulses.
  task automatic test_load_burst();
    exp_pulse = '{4, 8, 12};
    exp_done  = '{12};
    load = 1; div_in = 4; start = 1; mode = 1; burst_len = 3; enable = 1;
    @(posedge Clk); #1;
    load = 0; start = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge Clk); #1;
      if (pulse === 1'b1) begin
        checks++;
        if (exp_pulse.size() == 0 || exp_pulse[0] != k) begin
          errors++;
          $display("FAIL burst_pulse: pulse at edge %0d, expected edge %0d", k,
                   (exp_pulse.size() != 0) ? exp_pulse[0] : -1);
        end else void'(exp_pulse.pop_front());
      end
      if (done === 1'b1) begin
        checks++;
        if (exp_done.size() == 0 || exp_done[0] != k) begin
          errors++;
          $display("FAIL burst_done: done at edge %0d, expected edge %0d", k,
                   (exp_done.size() != 0) ? exp_done[0] : -1);
        end else void'(exp_done.pop_front());
      end
      if (k == 12) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL burst_busy_done_cycle: got %b, expected 1", busy);
        end
      end
      if (k == 13) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL burst_busy_after: got %b, expected 0", busy);
        end
      end
    end
    checks++;
    if (exp_pulse.size() != 0 || exp_done.size() != 0) begin
      errors++;
      $display("FAIL burst_missing: pulses left %0d done left %0d, expected 0 0",
               exp_pulse.size(), exp_done.size());
      exp_pulse.delete(); exp_done.delete();
    end
  endtask

  // Start held high: ignored during BURST, re-triggers from IDLE after done.
  task automatic test_back_to_back();
    exp_pulse = '{4, 8, 14, 18};
    exp_done  = '{8, 18};
    burst_len = 2; mode = 1; enable = 1; start = 1;
    @(posedge Clk); #1;  // entry edge (div still 4)
    for (int k = 1; k <= 19; k++) begin
      @(posedge Clk); #1;
      if (pulse === 1'b1) begin
        checks++;
        if (exp_pulse.size() == 0 || exp_pulse[0] != k) begin
          errors++;
          $display("FAIL b2b_pulse: pulse at edge %0d, expected edge %0d", k,
                   (exp_pulse.size() != 0) ? exp_pulse[0] : -1);
        end else void'(exp_pulse.pop_front());
      end
      if (done === 1'b1) begin
        checks++;
        if (exp_done.size() == 0 || exp_done[0] != k) begin
          errors++;
          $display("FAIL b2b_done: done at edge %0d, expected edge %0d", k,
                   (exp_done.size() != 0) ? exp_done[0] : -1);
        end else void'(exp_done.pop_front());
      end
      if (k == 9) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL b2b_idle_gap: busy %b, expected 0", busy);
        end
      end
    end
    start = 0; enable = 0;
    checks++;
    if (exp_pulse.size() != 0 || exp_done.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing: pulses left %0d done left %0d, expected 0 0",
               exp_pulse.size(), exp_done.size());
      exp_pulse.delete(); exp_done.delete();
    end
    repeat (2) @(posedge Clk);
    #1;
  endtask

  // Load while in CONT is rejected; period stays 10.
  task automatic test_rejected_load();
    exp_pulse = '{10, 20, 30, 40};
    load = 1; div_in = 10; enable = 0; mode = 0;
    @(posedge Clk); #1;
    load = 0; enable = 1;
    @(posedge Clk); #1;  // entry edge
    for (int k = 1; k <= 42; k++) begin
      @(posedge Clk); #1;
      load = 0;
      if (pulse === 1'b1) begin
        checks++;
        if (exp_pulse.size() == 0 || exp_pulse[0] != k) begin
          errors++;
          $display("FAIL rej_pulse: pulse at edge %0d, expected edge %0d", k,
                   (exp_pulse.size() != 0) ? exp_pulse[0] : -1);
        end else void'(exp_pulse.pop_front());
      end
      if (k == 14 || k == 15) begin
        checks++;
        if (load_err !== (k == 14)) begin
          errors++;
          $display("FAIL rej_load_err: edge %0d got %b, expected %b", k, load_err, (k == 14));
        end
      end
      if (k == 13) begin load = 1; div_in = 3; end
    end
    checks++;
    if (exp_pulse.size() != 0) begin
      errors++; $display("FAIL rej_missing: %0d pulses missing, expected 0", exp_pulse.size());
      exp_pulse.delete();
    end
    enable = 0;
    @(posedge Clk); #1;
  endtask

  // div_in 0 / 1 -> pulse every cycle; burst_len 0 -> single pulse with done.
  task automatic test_boundary();
    for (int d = 0; d <= 1; d++) begin
      load = 1; div_in = WIDTH'(d); enable = 1; mode = 0;
      @(posedge Clk); #1;
      load = 0;
      for (int k = 1; k <= 8; k++) begin
        @(posedge Clk); #1;
        checks++;
        if (pulse !== 1'b1) begin
          errors++; $display("FAIL div%0d_every_cycle: edge %0d pulse %b, expected 1", d, k, pulse);
        end
      end
      enable = 0;
      @(posedge Clk); #1;
      checks++;
      if (pulse !== 1'b0) begin
        errors++; $display("FAIL div%0d_stop: pulse %b, expected 0", d, pulse);
      end
    end
    exp_pulse = '{3};
    exp_done  = '{3};
    load = 1; div_in = 3; mode = 1; start = 1; burst_len = 0; enable = 1;
    @(posedge Clk); #1;
    load = 0; start = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge Clk); #1;
      if (pulse === 1'b1) begin
        checks++;
        if (exp_pulse.size() == 0 || exp_pulse[0] != k) begin
          errors++;
          $display("FAIL blen0_pulse: pulse at edge %0d, expected edge %0d", k,
                   (exp_pulse.size() != 0) ? exp_pulse[0] : -1);
        end else void'(exp_pulse.pop_front());
      end
      if (done === 1'b1) begin
        checks++;
        if (exp_done.size() == 0 || exp_done[0] != k) begin
          errors++;
          $display("FAIL blen0_done: done at edge %0d, expected edge %0d", k,
                   (exp_done.size() != 0) ? exp_done[0] : -1);
        end else void'(exp_done.pop_front());
      end
    end
    checks++;
    if (exp_pulse.size() != 0 || exp_done.size() != 0) begin
      errors++;
      $display("FAIL blen0_missing: pulses left %0d done left %0d, expected 0 0",
               exp_pulse.size(), exp_done.size());
      exp_pulse.delete(); exp_done.delete();
    end
    enable = 0;
    @(posedge Clk); #1;
  endtask

  // Abort a 5-pulse burst (div 8) after the second pulse.
  task automatic test_abort();
    exp_pulse = '{8, 16};
    load = 1; div_in = 8; mode = 1; start = 1; burst_len = 5; enable = 1;
    @(posedge Clk); #1;
    load = 0; start = 0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge Clk); #1;
      if (pulse === 1'b1) begin
        checks++;
        if (exp_pulse.size() == 0 || exp_pulse[0] != k) begin
          errors++;
          $display("FAIL abort_pulse: pulse at edge %0d, expected edge %0d", k,
                   (exp_pulse.size() != 0) ? exp_pulse[0] : -1);
        end else void'(exp_pulse.pop_front());
      end
      if (done === 1'b1) begin
        checks++; errors++;
        $display("FAIL abort_done: done at edge %0d, expected never", k);
      end
      if (k == 17) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL abort_busy: got %b, expected 0", busy);
        end
      end
      if (k == 16) enable = 0;
    end
    checks++;
    if (exp_pulse.size() != 0) begin
      errors++; $display("FAIL abort_missing: %0d pulses missing, expected 0", exp_pulse.size());
      exp_pulse.delete();
    end
  endtask

  // Async reset mid-run, then default divisor restored.
  task automatic test_reset_midrun();
    exp_pulse = '{DDIV};
    mode = 0; enable = 1;
    @(posedge Clk); #1;  // entry edge, div 8
    repeat (8) @(posedge Clk);
    #1;
    checks++;
    if (pulse !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL midrun_pre: pulse %b busy %b, expected 1 1", pulse, busy);
    end
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if ({pulse, busy, done, load_err} !== 4'b0000) begin
      errors++;
      $display("FAIL midrun_async: got %b, expected 0000", {pulse, busy, done, load_err});
    end
    enable = 0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL midrun_stay_idle: busy %b, expected 0", busy);
    end
    enable = 1; mode = 0;
    @(posedge Clk); #1;  // entry edge
    for (int k = 1; k <= DDIV + 3; k++) begin
      @(posedge Clk); #1;
      if (pulse === 1'b1) begin
        checks++;
        if (exp_pulse.size() == 0 || exp_pulse[0] != k) begin
          errors++;
          $display("FAIL midrun_pulse: pulse at edge %0d, expected edge %0d", k,
                   (exp_pulse.size() != 0) ? exp_pulse[0] : -1);
        end else void'(exp_pulse.pop_front());
      end
    end
    checks++;
    if (exp_pulse.size() != 0) begin
      errors++; $display("FAIL midrun_missing: %0d pulses missing, expected 0", exp_pulse.size());
      exp_pulse.delete();
    end
    enable = 0;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_load_burst();
    test_back_to_back();
    test_rejected_load();
    test_boundary();
    test_abort();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
